// File: rtl/keypad_scanner.sv
// keypad_scanner: one-hot 4x4 keypad row scanner with column debounce.
// Emits a registered key code, a one-cycle accept strobe and a held level.
`default_nettype none

module keypad_scanner #(
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk_1,
  input  logic       rst_n,
  input  logic [3:0] columns,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int MW = $clog2(DEBOUNCE_N + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(DEBOUNCE_N - 1);
  localparam logic [MW-1:0] MATCH_ONE  = MW'(1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t          state;
  logic [DW-1:0]   dwell;
  logic [MW-1:0]   match;
  logic [3:0]      cand;
  logic            sample;
  logic            press;
  logic [3:0]      next_row;

  assign sample   = (dwell == DWELL_LAST);
  assign press    = $onehot(columns);
  assign next_row = {rows[0], rows[3:1]};

  function automatic logic [3:0] encode(input logic [3:0] r, input logic [3:0] c);
    case ({r, c})
      8'b1000_1000: return 4'h1;
      8'b1000_0100: return 4'h2;
      8'b1000_0010: return 4'h3;
      8'b1000_0001: return 4'hA;
      8'b0100_1000: return 4'h4;
      8'b0100_0100: return 4'h5;
      8'b0100_0010: return 4'h6;
      8'b0100_0001: return 4'hB;
      8'b0010_1000: return 4'h7;
      8'b0010_0100: return 4'h8;
      8'b0010_0010: return 4'h9;
      8'b0010_0001: return 4'hC;
      8'b0001_1000: return 4'hE;
      8'b0001_0100: return 4'h0;
      8'b0001_0001: return 4'hD;
      default:      return 4'hF;
    endcase
  endfunction

  always_ff @(posedge clk_1) begin
    if (!rst_n) begin
      rows      <= 4'b1000;
      key_code  <= 4'hF;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      dwell     <= '0;
      match     <= '0;
      cand      <= 4'b0000;
      state     <= SCAN;
    end else begin
      key_valid <= 1'b0;
      dwell     <= sample ? '0 : dwell + 1'b1;
      if (sample) begin
        case (state)
          SCAN: begin
            if (press) begin
              cand <= columns;
              if (DEBOUNCE_N == 1) begin
                key_code  <= encode(rows, columns);
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                match     <= '0;
                state     <= HELD;
              end else begin
                match <= MATCH_ONE;
                state <= DEBOUNCE;
              end
            end else begin
              rows <= next_row;
            end
          end
          DEBOUNCE: begin
            if (columns == cand) begin
              if (match == MATCH_LAST) begin
                key_code  <= encode(rows, cand);
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                match     <= '0;
                state     <= HELD;
              end else begin
                match <= match + 1'b1;
              end
            end else begin
              match <= '0;
              rows  <= next_row;
              state <= SCAN;
            end
          end
          HELD: begin
            // The match counter doubles as the release counter here.
            if (columns == 4'b0000) begin
              if (match == MATCH_LAST) begin
                key_held <= 1'b0;
                match    <= '0;
                rows     <= next_row;
                state    <= SCAN;
              end else begin
                match <= match + 1'b1;
              end
            end else begin
              match <= '0;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized keypad stimulus checked every cycle against
// a behavioural scan/debounce model, plus literal spot checks.
`default_nettype none

module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DN = 3;

  logic       clk_1 = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] columns = 4'b0000;
  logic [3:0] rows, key_code;
  logic       key_valid, key_held;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_N(DN)) dut (
    .clk_1     (clk_1),
    .rst_n     (rst_n),
    .columns   (columns),
    .rows      (rows),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial forever #5 clk_1 = ~clk_1;

  int checks = 0;
  int fails  = 0;
  int nvalid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Physical keypad: a pressed key connects its column only while its row is driven.
  int         key_r = 0;
  logic [3:0] key_c = 4'b0000;
  logic       key_down = 1'b0;
  logic       force_en = 1'b0;
  logic [3:0] force_val = 4'b0000;

  always @(negedge clk_1) begin
    if (force_en)
      columns = force_val;
    else if (key_down && rows == (4'b1000 >> key_r))
      columns = key_c;
    else
      columns = 4'b0000;
  end

  // Behavioural model: row index, phase (0 scan, 1 debounce, 2 held), counters.
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  int         m_row, m_dwell, m_phase, m_cnt;
  logic [3:0] m_cand, m_code;
  logic       m_valid, m_held;
  bit         started = 0;

  function automatic int col_index(input logic [3:0] c);
    int ci = 0;
    for (int i = 0; i < 4; i++) if (c[3-i]) ci = i;
    return ci;
  endfunction

  always @(posedge clk_1) begin
    if (!rst_n) begin
      m_row = 0; m_dwell = 0; m_phase = 0; m_cnt = 0;
      m_cand = 4'b0000; m_code = 4'hF; m_valid = 0; m_held = 0;
      started = 1;
    end else if (started) begin
      m_valid = 0;
      if (m_dwell == SD - 1) begin
        m_dwell = 0;
        if (m_phase == 0) begin
          if ($countones(columns) == 1) begin
            m_cand = columns; m_cnt = 1; m_phase = 1;
          end else m_row = (m_row + 1) % 4;
        end else if (m_phase == 1) begin
          if (columns == m_cand) begin
            m_cnt++;
            if (m_cnt == DN) begin
              m_code = keymap[m_row*4 + col_index(m_cand)];
              m_valid = 1; m_held = 1; m_cnt = 0; m_phase = 2;
            end
          end else begin
            m_cnt = 0; m_row = (m_row + 1) % 4; m_phase = 0;
          end
        end else begin
          if (columns == 4'b0000) begin
            m_cnt++;
            if (m_cnt == DN) begin
              m_held = 0; m_cnt = 0; m_row = (m_row + 1) % 4; m_phase = 0;
            end
          end else m_cnt = 0;
        end
      end else m_dwell++;
    end
  end

  always @(negedge clk_1) begin
    if (started) begin
      check("rows", rows, 4'b1000 >> m_row);
      check("key_code", key_code, m_code);
      check("key_valid", key_valid, m_valid);
      check("key_held", key_held, m_held);
      if (key_valid === 1'b1) nvalid++;
    end
  end

  task automatic wait_valid(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_1);
      if (key_valid === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++; fails++;
      $display("FAIL %s: got no key_valid expected strobe within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_release(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_1);
      if (key_held === 1'b0) seen = 1;
    end
    if (!seen) begin
      checks++; fails++;
      $display("FAIL %s: got key_held stuck expected release within %0d cycles", name, budget);
    end
  endtask

  task automatic press_key(input string name, input int r, input logic [3:0] c, input logic [3:0] exp);
    key_r = r; key_c = c; key_down = 1'b1;
    wait_valid(name, 200);
    check(name, key_code, exp);
    repeat (6) @(negedge clk_1);
    key_down = 1'b0;
    wait_release(name, 200);
  endtask

  initial begin
    int v0;
    bit hit;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_1);
    check("reset_rows", rows, 4'b1000);
    check("reset_code", key_code, 4'hF);
    check("reset_valid", key_valid, 1'b0);
    check("reset_held", key_held, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_1);
    check("dwell_hold", rows, 4'b1000);
    @(negedge clk_1);
    check("first_step", rows, 4'b0100);
    repeat (12) @(negedge clk_1);
    check("wrap_step", rows, 4'b1000);

    // Key '5' with a release glitch that restarts the zero count.
    key_r = 1; key_c = 4'b0100; key_down = 1'b1;
    wait_valid("press5", 200);
    check("code5", key_code, 4'h5);
    check("held5", key_held, 1'b1);
    repeat (10) @(negedge clk_1);
    key_down = 1'b0;
    repeat (5) @(negedge clk_1);
    key_down = 1'b1;
    repeat (4) @(negedge clk_1);
    key_down = 1'b0;
    wait_release("release5", 100);
    check("release5_code", key_code, 4'h5);
    check("release5_rows", rows, 4'b0010);

    // Alternating press/no-press samples on row 0100 must never strobe.
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk_1);
      if (rows == 4'b0100) hit = 1;
    end
    v0 = nvalid;
    for (int i = 0; i < 12; i++) begin
      key_down = ~key_down;
      repeat (4) @(negedge clk_1);
    end
    key_down = 1'b0;
    repeat (8) @(negedge clk_1);
    check("alt_no_strobe", nvalid, v0);

    press_key("hash", 3, 4'b0010, 4'hF);
    press_key("star", 3, 4'b1000, 4'hE);
    press_key("keyA", 0, 4'b0001, 4'hA);

    // Reset in the middle of debounce.
    key_r = 2; key_c = 4'b0100; key_down = 1'b1;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk_1);
      if (m_phase == 1) hit = 1;
    end
    check("reached_debounce", hit, 1'b1);
    rst_n = 1'b0;
    key_down = 1'b0;
    v0 = nvalid;
    @(negedge clk_1);
    check("mid_rst_rows", rows, 4'b1000);
    check("mid_rst_held", key_held, 1'b0);
    rst_n = 1'b1;
    repeat (60) @(negedge clk_1);
    check("mid_rst_no_strobe", nvalid, v0);

    // Multi-hot columns are no press.
    force_en = 1'b1; force_val = 4'b1100;
    repeat (40) @(negedge clk_1);
    check("multihot_no_strobe", nvalid, v0);
    force_en = 1'b0;

    // Random presses, releases and column noise.
    for (int n = 0; n < 40; n++) begin
      key_r = int'($urandom_range(0, 3));
      key_c = 4'b0001 << $urandom_range(0, 3);
      key_down = 1'b1;
      repeat ($urandom_range(10, 80)) @(negedge clk_1);
      if ($urandom_range(0, 3) == 0) begin
        force_en = 1'b1; force_val = 4'($urandom);
        repeat ($urandom_range(1, 6)) @(negedge clk_1);
        force_en = 1'b0;
      end
      key_down = ($urandom_range(0, 4) == 0);
      repeat ($urandom_range(10, 60)) @(negedge clk_1);
      key_down = 1'b0;
      repeat ($urandom_range(0, 20)) @(negedge clk_1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the 4x4 matrix keypad rows one-hot and samples the column lines.
- Debounces a single key press and reports it as a 4-bit key code with a one-cycle valid strobe and a held level.
- Sits between the keypad pins and the key-code consumers.
- Produces the row pattern that the keypad decoding logic expects, and uses the same key-code encoding.

Parameters:
- SCAN_DIV, 1000, clk_1 cycles each row stays driven (dwell); legal range ≥2.
- DEBOUNCE_N, 4, consecutive matching samples required to accept a press or a release; legal range ≥1.

Ports:
- clk_1  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- columns  input  4  keypad column lines, active-high; a valid press is exactly one bit set.
- rows  output  4  one-hot row drive: 1000, 0100, 0010, 0001.
- key_code  output  4  encoded key of the last accepted press.
- key_valid  output  1  one-cycle strobe when a press is accepted.
- key_held  output  1  high while the accepted key remains pressed.

Behaviour:
- Reset is synchronous: rst_n low at a clk_1 edge gives:
  - rows=1000, key_code=4'hF, key_valid=0, key_held=0
  - dwell counter=0, match counter=0, state=SCAN
- Reset overrides everything, including mid-debounce or held states. No key_valid is produced on that edge.
- Dwell counter runs 0..SCAN_DIV-1 and then wraps.
  - "Sample edge" = the edge at which the counter equals SCAN_DIV-1.
  - columns is evaluated only on sample edges, giving SCAN_DIV-1 cycles of settling.
- The row advances only on sample edges, in the order 1000→0100→0010→0001→1000, and only in the cases stated below.
- "Press sample" = columns is one-hot. Zero or multi-hot columns count as no press.
- State SCAN:
  - Press sample: capture candidate column, freeze rows, match counter=1.
  - If DEBOUNCE_N=1, go directly to HELD with the accept actions. Otherwise go to DEBOUNCE.
  - No press: advance the row and stay in SCAN.
- State DEBOUNCE (rows frozen):
  - On each sample edge, if columns equals the candidate, increment the match counter.
  - When the counter reaches DEBOUNCE_N, perform the accept actions and go to HELD.
  - Any mismatch (zero, a different column, or multi-hot): match counter=0, advance the row, return to SCAN, no strobe.
- Accept actions, all on the same edge:
  - key_code=encode(rows, candidate)
  - key_valid=1 for exactly one cycle
  - key_held=1
  - match counter=0
- State HELD (rows frozen):
  - Columns==0 on a sample edge increments the release counter. Any nonzero sample clears it; other keys in the row are ignored.
  - When the release counter reaches DEBOUNCE_N:
    - key_held=0 and the release counter clears.
    - The row advances and the state returns to SCAN.
    - key_code keeps its last value.
- Encoding (rows / columns → key_code):
  - row 1000: col 1000=1, 0100=2, 0010=3, 0001=A
  - row 0100: col 1000=4, 0100=5, 0010=6, 0001=B
  - row 0010: col 1000=7, 0100=8, 0010=9, 0001=C
  - row 0001: col 1000=E (*), 0100=0, 0010=F (#), 0001=D
- '#' encodes F, the same value as idle; consumers distinguish the two by key_valid.
- Latency: key_valid rises (DEBOUNCE_N-1)*SCAN_DIV cycles after the edge of the first matching sample.
- key_valid is never asserted twice for one press; another strobe requires release then re-acceptance.
- All outputs are registered; there are no combinational paths from columns to outputs.

Test Plan (SCAN_DIV=4, DEBOUNCE_N=3):
- Reset, then columns=0 → rows=1000, key_code=F, key_valid=0; rows then steps 1000→0100→0010→0001→1000, changing every 4 cycles.
- columns=0100 held from while rows=0100 → rows freezes at 0100; key_valid pulses 1 cycle 8 cycles after the first sample edge; key_code=5, key_held=1.
- While rows=0100, columns alternates 0100/0000 on successive sample edges → no key_valid; the row advances to 0010 after the mismatch, and scanning resumes.
- After the held '5', columns=0000 → key_held drops on the 3rd zero sample edge; rows→0010; key_code stays 5. A glitch (nonzero) on the 2nd zero sample restarts the count.
- rows=0001 with columns=0010 → key_valid=1, key_code=F. Repeat with columns=1000 → key_code=E. rows=1000 with columns=0001 → key_code=A.
- rst_n low during DEBOUNCE → next edge gives rows=1000, key_held=0, and no strobe ever appears. columns=1100 → treated as no press and scanning continues.
